// File: rtl/karatsuba_mul_scheduler.sv
// rtl/karatsuba_mul_scheduler.sv - round-robin scheduler sharing one fixed-latency carry-less multiplier
// Optional zero-operand bypass: MULSCHED_ZERO_BYPASS_EN
module karatsuba_mul_scheduler #(
    parameter int WIDTH   = 283,
    parameter int NREQ    = 4,
    parameter int LATENCY = 3,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*WIDTH-1:0]   req_a_i,
    input  logic [NREQ*WIDTH-1:0]   req_b_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic                    rsp_valid_o,
    output logic [IDW-1:0]          rsp_id_o,
    output logic [2*WIDTH-1:0]      rsp_c_o,
    input  logic                    rsp_ready_i,
    output logic [WIDTH-1:0]        mul_a_o,
    output logic [WIDTH-1:0]        mul_b_o,
    output logic                    mul_start_o,
    input  logic [2*WIDTH-1:0]      mul_c_i,
    output logic                    busy_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [2*WIDTH-1:0] rsp_c_q, rsp_c_d;

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;

    // Search starts one past the last winner so every holder is served within NREQ grants.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant_q) + k) % NREQ;
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    assign sel_a = req_a_i[int'(grant_idx)*WIDTH +: WIDTH];
    assign sel_b = req_b_i[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        req_ready_o = '0;
        if (state_q == S_IDLE && grant_found) begin
            req_ready_o = NREQ'(1) << grant_idx;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        rsp_id_d     = rsp_id_q;
        rsp_c_d      = rsp_c_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    rsp_id_d     = grant_idx;
                    last_grant_d = grant_idx;
`ifdef MULSCHED_ZERO_BYPASS_EN
                    if (sel_a == '0 || sel_b == '0) begin
                        rsp_c_d = '0;
                        state_d = S_RESP;
                    end else begin
                        mul_a_d = sel_a;
                        mul_b_d = sel_b;
                        state_d = S_LAUNCH;
                    end
`else
                    mul_a_d = sel_a;
                    mul_b_d = sel_b;
                    state_d = S_LAUNCH;
`endif
                end
            end
            S_LAUNCH: begin
                cnt_d   = 4'(LATENCY);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Counting down through zero samples mul_c one edge after it settles.
                if (cnt_q == 4'd0) begin
                    rsp_c_d = mul_c_i;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_id_q     <= '0;
            rsp_c_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_id_q     <= rsp_id_d;
            rsp_c_q      <= rsp_c_d;
        end
    end

    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign mul_start_o = (state_q == S_LAUNCH);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_id_o    = rsp_id_q;
    assign rsp_c_o     = rsp_c_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
